// File: rtl/fanout_repeater_pipe.sv
// Pipelined fanout distributor: one driver value is sent to NUM_LOADS branches through
// per-branch chains of registered repeater stages. A flush FSM drains the branches.
module fanout_repeater_pipe #(
  parameter int unsigned              WIDTH        = 8,
  parameter int unsigned              NUM_LOADS    = 3,
  parameter logic [4*NUM_LOADS-1:0]   BRANCH_DEPTH = {4'd1, 4'd1, 4'd1},
  parameter int unsigned              EQUALIZE     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           drvr_data,
  input  logic                       drvr_valid,
  input  logic [NUM_LOADS-1:0]       branch_en,
  input  logic                       flush,
  output logic [NUM_LOADS*WIDTH-1:0] load_data,
  output logic [NUM_LOADS-1:0]       load_valid,
  output logic [WIDTH-1:0]           load_output,
  output logic                       busy,
  output logic                       flush_done
);

  function automatic int unsigned calc_dmax();
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < NUM_LOADS; i++) begin
      if (32'(BRANCH_DEPTH[4*i +: 4]) > m) m = 32'(BRANCH_DEPTH[4*i +: 4]);
    end
    return m;
  endfunction

  localparam int unsigned DMAX = calc_dmax();

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 accepting;
  logic [NUM_LOADS-1:0] branch_busy;

  assign load_output = drvr_data;
  assign busy        = |branch_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accepting  = 1'b0;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        accepting = 1'b1;
        if (flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!busy) state_nxt = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_nxt  = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  for (genvar i = 0; i < NUM_LOADS; i++) begin : g_branch
    localparam int unsigned D = (EQUALIZE != 0) ? DMAX : 32'(BRANCH_DEPTH[4*i +: 4]);

    logic valid_in;
    assign valid_in = drvr_valid & branch_en[i] & accepting;

    if (D == 0) begin : g_comb
      assign load_valid[i]               = valid_in;
      assign load_data[WIDTH*i +: WIDTH] = drvr_data;
      assign branch_busy[i]              = 1'b0;
    end else begin : g_pipe
      logic [D-1:0]     stage_valid;
      logic [WIDTH-1:0] stage_data [D];

      // Data registers only load alongside a valid, so outputs hold the last delivery.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_valid <= '0;
          for (int unsigned k = 0; k < D; k++) stage_data[k] <= '0;
        end else begin
          stage_valid[0] <= valid_in;
          if (valid_in) stage_data[0] <= drvr_data;
          for (int unsigned k = 1; k < D; k++) begin
            stage_valid[k] <= stage_valid[k-1];
            if (stage_valid[k-1]) stage_data[k] <= stage_data[k-1];
          end
        end
      end

      assign load_valid[i]               = stage_valid[D-1];
      assign load_data[WIDTH*i +: WIDTH] = stage_data[D-1];
      assign branch_busy[i]              = |stage_valid;
    end
  end

endmodule

// File: tb/tb_fanout_repeater_pipe.sv
// Scoreboard bench for fanout_repeater_pipe: three configurations share the driver inputs;
// expected deliveries (arrival cycle + data) are queued at drive time and popped on load_valid.
module tb_fanout_repeater_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  drvr_data = 8'h00;
  logic        drvr_valid = 1'b0;
  logic [2:0]  branch_en = 3'b111;
  logic        flush = 1'b0;
  logic        fl_off = 1'b0;

  logic [23:0] ld_all   [3];
  logic [2:0]  lv_all   [3];
  logic [7:0]  lo_all   [3];
  logic        busy_all [3];
  logic        fd_all   [3];

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic        f_accept = 1'b1;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
  } exp_t;

  exp_t        sbq [9][$];
  int unsigned depth_tab [9] = '{0, 1, 2, 2, 2, 2, 3, 3, 3};

  fanout_repeater_pipe #(.WIDTH(8), .NUM_LOADS(3), .BRANCH_DEPTH({4'd2, 4'd1, 4'd0}), .EQUALIZE(0)) dut_a (
    .clk(clk), .rst(rst), .drvr_data(drvr_data), .drvr_valid(drvr_valid), .branch_en(branch_en),
    .flush(fl_off), .load_data(ld_all[0]), .load_valid(lv_all[0]), .load_output(lo_all[0]),
    .busy(busy_all[0]), .flush_done(fd_all[0]));

  fanout_repeater_pipe #(.WIDTH(8), .NUM_LOADS(3), .BRANCH_DEPTH({4'd2, 4'd1, 4'd0}), .EQUALIZE(1)) dut_e (
    .clk(clk), .rst(rst), .drvr_data(drvr_data), .drvr_valid(drvr_valid), .branch_en(branch_en),
    .flush(fl_off), .load_data(ld_all[1]), .load_valid(lv_all[1]), .load_output(lo_all[1]),
    .busy(busy_all[1]), .flush_done(fd_all[1]));

  fanout_repeater_pipe #(.WIDTH(8), .NUM_LOADS(3), .BRANCH_DEPTH({4'd3, 4'd3, 4'd3}), .EQUALIZE(0)) dut_f (
    .clk(clk), .rst(rst), .drvr_data(drvr_data), .drvr_valid(drvr_valid), .branch_en(branch_en),
    .flush(flush), .load_data(ld_all[2]), .load_valid(lv_all[2]), .load_output(lo_all[2]),
    .busy(busy_all[2]), .flush_done(fd_all[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int n = 0; n < 3; n++) begin
        for (int b = 0; b < 3; b++) begin
          if (lv_all[n][b] === 1'b1) begin
            total++;
            if (sbq[n*3+b].size() == 0) begin
              bad++;
              $display("FAIL unexpected_valid dut%0d br%0d cyc=%0d: got valid data=%h, required no valid",
                       n, b, cyc, ld_all[n][b*8 +: 8]);
            end else begin
              e = sbq[n*3+b].pop_front();
              if (e.cyc !== cyc || ld_all[n][b*8 +: 8] !== e.data) begin
                bad++;
                $display("FAIL delivery dut%0d br%0d: got cyc=%0d data=%h, required cyc=%0d data=%h",
                         n, b, cyc, ld_all[n][b*8 +: 8], e.cyc, e.data);
              end
            end
          end
        end
      end
    end
  end

  task automatic clear_sb();
    for (int i = 0; i < 9; i++) sbq[i].delete();
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic fl);
    @(posedge clk); #1;
    drvr_data  = d;
    drvr_valid = v;
    flush      = fl;
    for (int n = 0; n < 3; n++) begin
      for (int b = 0; b < 3; b++) begin
        logic acc;
        exp_t e;
        acc = (n == 2) ? f_accept : 1'b1;
        if (v && branch_en[b] && acc) begin
          e.cyc  = cyc + depth_tab[n*3+b];
          e.data = d;
          sbq[n*3+b].push_back(e);
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    drvr_valid = 1'b0;
    flush      = 1'b0;
    rst        = 1'b1;
    f_accept   = 1'b1;
    clear_sb();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_drained(input string name);
    int left;
    repeat (5) step(8'h00, 1'b0, 1'b0);
    left = 0;
    for (int i = 0; i < 9; i++) left += sbq[i].size();
    total++;
    if (left != 0) begin
      bad++;
      $display("FAIL drained_%s: got %0d undelivered words, required 0", name, left);
    end
  endtask

  task automatic test_reset();
    drvr_data = 8'h5A;
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      total++;
      if (lv_all[n] !== 3'b000 || busy_all[n] !== 1'b0 || fd_all[n] !== 1'b0) begin
        bad++;
        $display("FAIL reset_ctrl dut%0d: got valid=%b busy=%b done=%b, required 000 0 0",
                 n, lv_all[n], busy_all[n], fd_all[n]);
      end
      total++;
      if (lo_all[n] !== 8'h5A) begin
        bad++;
        $display("FAIL reset_tap dut%0d: got %h, required 5a", n, lo_all[n]);
      end
    end
    total++;
    if (ld_all[0] !== 24'h00005A) begin
      bad++;
      $display("FAIL reset_data_a: got %h, required 00005a", ld_all[0]);
    end
    total++;
    if (ld_all[1] !== 24'h0 || ld_all[2] !== 24'h0) begin
      bad++;
      $display("FAIL reset_data_ef: got %h %h, required 000000 000000", ld_all[1], ld_all[2]);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_latency();
    logic [2:0] exp_a [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
    logic [2:0] exp_e [4] = '{3'b000, 3'b000, 3'b111, 3'b000};
    logic [2:0] exp_f [4] = '{3'b000, 3'b000, 3'b000, 3'b111};
    branch_en = 3'b111;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) step(8'hA5, 1'b1, 1'b0);
      else        step(8'h00, 1'b0, 1'b0);
      @(negedge clk);
      total++;
      if (lv_all[0] !== exp_a[t] || lv_all[1] !== exp_e[t] || lv_all[2] !== exp_f[t]) begin
        bad++;
        $display("FAIL latency_t%0d: got a=%b e=%b f=%b, required a=%b e=%b f=%b",
                 t, lv_all[0], lv_all[1], lv_all[2], exp_a[t], exp_e[t], exp_f[t]);
      end
    end
    check_drained("latency");
  endtask

  task automatic test_enable();
    apply_reset();
    branch_en = 3'b101;
    for (int i = 0; i < 10; i++) step(8'(i), 1'b1, 1'b0);
    check_drained("enable");
    for (int n = 0; n < 3; n++) begin
      total++;
      if (ld_all[n][15:8] !== 8'h00) begin
        bad++;
        $display("FAIL enable_hold dut%0d: got br1 data=%h, required 00", n, ld_all[n][15:8]);
      end
    end
    total++;
    if (ld_all[0][23:16] !== 8'h09) begin
      bad++;
      $display("FAIL enable_last: got br2 data=%h, required 09", ld_all[0][23:16]);
    end
    branch_en = 3'b111;
  endtask

  task automatic test_flush();
    logic exp_busy;
    logic exp_fd;
    apply_reset();
    branch_en = 3'b111;
    for (int i = 0; i < 3; i++) step(8'h40 + 8'(i), 1'b1, 1'b0);
    step(8'h50, 1'b1, 1'b1);
    @(negedge clk);
    total++;
    if (busy_all[2] !== 1'b1 || fd_all[2] !== 1'b0) begin
      bad++;
      $display("FAIL flush_t0: got busy=%b done=%b, required 1 0", busy_all[2], fd_all[2]);
    end
    for (int k = 1; k <= 8; k++) begin
      f_accept = (k >= 6);
      step(8'h50 + 8'(k), 1'b1, (k == 2 || k == 5));
      @(negedge clk);
      exp_busy = (k <= 3) || (k >= 7);
      exp_fd   = (k == 5);
      total++;
      if (busy_all[2] !== exp_busy || fd_all[2] !== exp_fd) begin
        bad++;
        $display("FAIL flush_t%0d: got busy=%b done=%b, required %b %b",
                 k, busy_all[2], fd_all[2], exp_busy, exp_fd);
      end
    end
    f_accept = 1'b1;
    check_drained("flush");
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    for (int i = 0; i < 3; i++) step(8'h60 + 8'(i), 1'b1, 1'b0);
    step(8'h63, 1'b1, 1'b1);
    f_accept = 1'b0;
    step(8'h64, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (busy_all[2] !== 1'b1) begin
      bad++;
      $display("FAIL midrain_pre: got busy=%b, required 1", busy_all[2]);
    end
    #1 rst = 1'b1;
    clear_sb();
    #1;
    total++;
    if (lv_all[2] !== 3'b000 || ld_all[2] !== 24'h0 || busy_all[2] !== 1'b0 || fd_all[2] !== 1'b0) begin
      bad++;
      $display("FAIL midrain_async: got valid=%b data=%h busy=%b done=%b, required 000 000000 0 0",
               lv_all[2], ld_all[2], busy_all[2], fd_all[2]);
    end
    total++;
    if (lv_all[0] !== 3'b000 || ld_all[0][23:8] !== 16'h0) begin
      bad++;
      $display("FAIL midrain_a: got valid=%b data=%h, required 000 0000", lv_all[0], ld_all[0][23:8]);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    f_accept = 1'b1;
    step(8'h77, 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      total++;
      if (fd_all[2] !== 1'b0) begin
        bad++;
        $display("FAIL midrain_nodone_%0d: got done=%b, required 0", j, fd_all[2]);
      end
      step(8'h00, 1'b0, 1'b0);
    end
    check_drained("midrain");
  endtask

  task automatic test_tap_hold();
    logic [7:0] pat [6] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};
    for (int i = 0; i < 6; i++) begin
      step(pat[i], 1'b0, 1'b0);
      #1;
      total++;
      if (lo_all[0] !== pat[i] || lo_all[2] !== pat[i]) begin
        bad++;
        $display("FAIL tap_%0d: got a=%h f=%h, required %h", i, lo_all[0], lo_all[2], pat[i]);
      end
      total++;
      if (ld_all[0][15:8] !== 8'h77 || ld_all[2][7:0] !== 8'h77) begin
        bad++;
        $display("FAIL hold_%0d: got a_br1=%h f_br0=%h, required 77 77", i, ld_all[0][15:8], ld_all[2][7:0]);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 drvr_data = pat[5-i];
      #1;
      total++;
      if (lo_all[1] !== pat[5-i]) begin
        bad++;
        $display("FAIL tap_rst_%0d: got %h, required %h", i, lo_all[1], pat[5-i]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_enable();
    test_flush();
    test_reset_mid_drain();
    test_tap_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
